stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Supersedes the fixed 4:1 combinational mux wherever data sources are streams rather than static levels.
- Selection is either fixed, from an external sel, or round-robin fair arbitration among valid channels.
- One registered output stage; sits between multiple producers and a single consumer, in the same asynchronous/synchronous HDL library.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, width of sel and out_chan; must satisfy N <= 2**SELW.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, released synchronously by the system.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has a word.
- in_ready  output  N  channel i word accepted this cycle.
- sel  input  SELW  channel index used in fixed mode.
- mode  input  1  0 = fixed sel, 1 = round-robin.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_chan=0, last_grant=N-1 (channel 0 has first round-robin priority); in_ready=0 while in reset. Any word held in the output register is discarded.
- load_en = !out_valid || out_ready. The output register loads only when load_en=1.
- Arbitration is evaluated combinationally each cycle; winner g exists only when load_en=1.
  - mode=0: g = sel if sel < N and in_valid[sel]=1; otherwise no winner. sel >= N never grants.
  - mode=1: g = first i with in_valid[i]=1, scanning cyclically from last_grant+1 (wrapping N-1 -> 0). last_grant itself is checked last.
- in_ready[i] = load_en && winner exists && i==g. At most one bit is set (one-hot or zero). in_ready does not depend on in_valid of other channels in mode 0.
- On a clock edge with a winner:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In mode 1 only, last_grant <= g. Mode 0 grants do not update last_grant.
- On a clock edge with load_en=1 and no winner: out_valid <= 0; out_data and out_chan hold.
- On a clock edge with load_en=0 (out_valid=1, out_ready=0): all outputs hold; in_ready is all zero.
- Latency: 1 cycle from input transfer to out_valid. Full throughput is one word per cycle when out_ready stays 1; back-to-back transfers are allowed with no bubble.
- Simultaneous pop and push: with out_valid=1, out_ready=1 and a winner, the old word leaves and the new word loads in the same edge.
- Changes to mode or sel take effect on the next arbitration; a word already held is unaffected.
- Handshake rules: no combinational path from in_data to out_data. The out_ready -> in_ready path is combinational and permitted. out_valid never drops without a transfer (out_ready=1) unless reset.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, before any clock edge.
- Fixed mode: N=4, mode=0, sel=2, in_valid=4'b1111, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> in_ready=0; following cycle out_valid=0.
- Round-robin fairness: mode=1, in_valid=4'b1011 held, out_ready=1 -> out_chan sequence 0,1,3,0,1,3; channel 2 is never granted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_data stable throughout. On out_ready=1, the next winner loads that same edge with no bubble.
- Wrap/priority: mode=1, last grant 3, in_valid=4'b1001 -> grant 0, then 3.
- Out-of-range select: N=3, SELW=2, mode=0, sel=3 -> never grants. Switching to mode=1 grants on the next cycle.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input registered stream mux, fixed-select or round-robin; 1-cycle latency.
// Backpressure: the output register loads only when empty or being popped, so in_ready follows out_ready combinationally.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [SELW-1:0]      out_chan_q;
    logic [SELW-1:0]      last_grant_q;

    logic                 load_en;
    logic                 win_vld;
    logic [SELW-1:0]      win_idx;
    logic [WIDTH-1:0]     win_data;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        int c;
        c        = 0;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_data = '0;
        if (!mode) begin
            // sel >= N never matches any channel, so it can never grant
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    win_vld  = 1'b1;
                    win_idx  = SELW'(i);
                    win_data = in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = int'(last_grant_q) + k;
                if (c >= N) c = c - N;
                for (int i = 0; i < N; i++) begin
                    if (!win_vld && i == c && in_valid[i]) begin
                        win_vld  = 1'b1;
                        win_idx  = SELW'(i);
                        win_data = in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && win_vld) begin
            for (int i = 0; i < N; i++) begin
                in_ready[i] = (win_idx == SELW'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SELW'(N-1);
        end else if (load_en) begin
            if (win_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_chan_q  <= win_idx;
                if (mode) last_grant_q <= win_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance and a 3-channel instance for out-of-range select.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst_n;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [1:0]  a_sel;
    logic        a_mode;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_chan;
    logic        a_out_valid;
    logic        a_out_ready;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_sel;
    logic        b_mode;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_chan;
    logic        b_out_valid;
    logic        b_out_ready;

    int total = 0;
    int bad   = 0;

    stream_mux_rr #(.WIDTH(8), .N(4), .SELW(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .mode(a_mode),
        .out_data(a_out_data), .out_chan(a_out_chan),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .N(3), .SELW(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .mode(b_mode),
        .out_data(b_out_data), .out_chan(b_out_chan),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst_n       = 1'b0;
        a_in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        a_in_valid  = '0;
        a_sel       = '0;
        a_mode      = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = {8'hB3, 8'hB2, 8'hB1};
        b_in_valid  = '0;
        b_sel       = '0;
        b_mode      = 1'b0;
        b_out_ready = 1'b0;

        #2;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_data",  a_out_data, 0);
        chk("rst_chan",  a_out_chan, 0);
        a_in_valid = 4'b1111;
        #1;
        chk("rst_in_ready", a_in_ready, 0);

        step();
        rst_n = 1'b1;

        // Fixed mode
        a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        #1;
        chk("fix_in_ready", a_in_ready, 4'b0100);
        step();
        chk("fix_data",  a_out_data, 8'hA5);
        chk("fix_chan",  a_out_chan, 2);
        chk("fix_valid", a_out_valid, 1);
        a_sel = 2'd3; a_in_valid = 4'b0111;
        #1;
        chk("fix_nowin_ready", a_in_ready, 0);
        step();
        chk("fix_nowin_valid", a_out_valid, 0);
        chk("fix_nowin_hold",  a_out_data, 8'hA5);
        chk("fix_nowin_chan",  a_out_chan, 2);

        // Round-robin, channel 2 idle; last grant still N-1 from reset
        a_mode = 1'b1; a_in_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_in_ready", a_in_ready, 4'b0001 << rr_exp[k]);
            step();
            chk("rr_chan", a_out_chan, rr_exp[k]);
            chk("rr_valid", a_out_valid, 1);
        end
        chk("rr_last_data", a_out_data, 8'h44);

        // Backpressure holds word 0x44 from channel 3
        a_out_ready = 1'b0; a_in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", a_in_ready, 0);
            step();
            chk("bp_data",  a_out_data, 8'h44);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_chan",  a_out_chan, 3);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 4'b0001);
        step();
        chk("wrap_chan0", a_out_chan, 0);
        chk("wrap_data0", a_out_data, 8'h11);
        chk("wrap_valid", a_out_valid, 1);
        step();
        chk("wrap_chan3", a_out_chan, 3);

        // Out-of-range select on the 3-channel instance
        b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
        #1;
        chk("oor_in_ready", b_in_ready, 0);
        step();
        chk("oor_valid0", b_out_valid, 0);
        step();
        chk("oor_valid1", b_out_valid, 0);
        b_mode = 1'b1;
        #1;
        chk("oor_rr_ready", b_in_ready, 3'b001);
        step();
        chk("oor_rr_valid", b_out_valid, 1);
        chk("oor_rr_chan",  b_out_chan, 0);
        chk("oor_rr_data",  b_out_data, 8'hB1);

        // Asynchronous reset mid-stream, between clock edges
        chk("pre_rst_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_data",  a_out_data, 0);
        chk("arst_chan",  a_out_chan, 0);
        chk("arst_ready", a_in_ready, 0);
        #1;
        rst_n = 1'b1;

        // After reset channel 0 has round-robin priority again
        a_mode = 1'b1; a_in_valid = 4'b1111; a_out_ready = 1'b1;
        step();
        chk("post_rst_chan", a_out_chan, 0);
        // A fixed-mode grant must not move the round-robin pointer
        a_mode = 1'b0; a_sel = 2'd3;
        step();
        chk("fix_grant_chan", a_out_chan, 3);
        a_mode = 1'b1;
        step();
        chk("rr_after_fix", a_out_chan, 1);
        chk("rr_after_fix_data", a_out_data, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
